pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 64: width of the staged payload (e.g. {pcAdd4, instruction}).
REQ-002 Parameter MAX_HOLD, default 1: maximum consecutive cycles a hold request is honoured before a forced load; 0 means unlimited.
REQ-003 Parameter NOP_VALUE, default all-zero DATA_W: payload inserted on reset and flush.
REQ-004 Derived CNT_W SHALL equal max(1, clog2(MAX_HOLD+1)) when MAX_HOLD>0, and 8 when MAX_HOLD=0.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 hold  input  1  stall request from the hazard unit.
REQ-008 flush  input  1  squash request; inserts a bubble.
REQ-009 validIn  input  1  upstream payload valid.
REQ-010 dataIn  input  DATA_W  upstream payload.
REQ-011 validOut  output  1  registered payload valid.
REQ-012 dataOut  output  DATA_W  registered payload.
REQ-013 holding  output  1  registered; 1 when the last edge honoured a hold.
REQ-014 holdCount  output  CNT_W  consecutive honoured-hold count.
REQ-015 holdExpired  output  1  registered one-cycle pulse on a forced load.

Function
REQ-016 States: RUN (holding=0) and HOLD (holding=1); all outputs SHALL be registered, with no combinational input-to-output path.
REQ-017 Per-edge priority SHALL be rst > flush > honoured hold > load.
REQ-018 Hold is honoured when hold=1 and (MAX_HOLD=0 or holdCount<MAX_HOLD).
REQ-019 Honoured hold: dataOut/validOut unchanged, holdCount+1 (saturating at all-ones when MAX_HOLD=0), state HOLD, holdExpired=0.
REQ-020 Forced load (hold=1, MAX_HOLD>0, holdCount=MAX_HOLD): dataOut<=dataIn, validOut<=validIn, holdCount<=0, state RUN, holdExpired<=1.
REQ-021 Normal load (hold=0, no flush): dataOut<=dataIn, validOut<=validIn, holdCount<=0, state RUN, holdExpired<=0.
REQ-022 Flush: dataOut<=NOP_VALUE, validOut<=0, holdCount<=0, state RUN, holdExpired<=0, regardless of hold or holdCount.
REQ-023 Latency SHALL be exactly one edge from dataIn to dataOut on any load.
REQ-024 With hold held high continuously and MAX_HOLD=N>0, the register SHALL repeat a cycle of N frozen edges followed by 1 forced load.
REQ-025 Under MAX_HOLD=0, the saturated counter SHALL NOT force a load; hold SHALL be honoured indefinitely.
REQ-026 holdExpired SHALL be high for exactly one cycle per forced load and otherwise 0.
REQ-027 validIn=0 on a load SHALL still capture dataIn; validOut marks it invalid.

Reset
REQ-028 On rst=1 at an edge: dataOut=NOP_VALUE, validOut=0, holding=0, holdCount=0, holdExpired=0, state RUN, overriding flush and hold.
REQ-029 Reset asserted mid-hold SHALL discard hold progress; the first edge after release behaves per REQ-017 from holdCount=0.

Verification
REQ-030 rst=1 for 2 edges with hold=1 and flush=1 -> dataOut=0, validOut=0, holdCount=0, holding=0.
REQ-031 MAX_HOLD=1: load A, then hold=1 for 4 edges with dataIn=B -> dataOut A,B,B,B; holdExpired pulses after edges 2 and 4.
REQ-032 MAX_HOLD=3: hold=1 for 5 edges, dataIn=C -> holdCount 1,2,3,0,1; dataOut=C after edge 4; holdExpired=1 only after edge 4.
REQ-033 Flush during HOLD (holdCount=2, hold=1) -> next edge dataOut=NOP_VALUE, validOut=0, holdCount=0, holding=0.
REQ-034 MAX_HOLD=0: hold=1 for 300 edges -> dataOut frozen, holdCount saturates at 255, holdExpired never 1; drop hold -> load on next edge.
REQ-035 Back-to-back loads with alternating validIn 1/0 and payload 0x1,0x2,0x3 -> dataOut follows one edge later; validOut 1/0 matches.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with bounded hold (stall), flush-to-bubble and a
// registered hold status. Every output is a flop; nothing passes straight through.
module pipe_stage_reg #(
    parameter int                 DATA_W    = 64,
    parameter int                 MAX_HOLD  = 1,
    parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
    localparam int                CNT_W     = (MAX_HOLD == 0) ? 8 :
                                              (($clog2(MAX_HOLD + 1) < 1) ? 1 : $clog2(MAX_HOLD + 1))
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              validIn,
    input  logic [DATA_W-1:0] dataIn,
    output logic              validOut,
    output logic [DATA_W-1:0] dataOut,
    output logic              holding,
    output logic [CNT_W-1:0]  holdCount,
    output logic              holdExpired
);

    // Valid semantics: validIn qualifies dataIn at the edge where the stage
    // loads; dataIn is captured even when validIn=0, and validOut qualifies
    // dataOut. There is no ready: back-pressure comes only from hold.

    localparam logic [0:0]       RUN   = 1'b0;
    localparam logic [0:0]       HOLD  = 1'b1;
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_HOLD);

    logic [0:0]       state;
    logic             hold_ok;
    logic [CNT_W-1:0] cnt_inc;

    // With MAX_HOLD=0 the count saturates and the hold is never cut short.
    assign hold_ok = hold && ((MAX_HOLD == 0) || (holdCount < MAX_C));
    assign cnt_inc = (&holdCount) ? holdCount : holdCount + CNT_W'(1);
    assign holding = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            dataOut     <= NOP_VALUE;
            validOut    <= 1'b0;
            holdCount   <= '0;
            holdExpired <= 1'b0;
        end else if (flush) begin
            state       <= RUN;
            dataOut     <= NOP_VALUE;
            validOut    <= 1'b0;
            holdCount   <= '0;
            holdExpired <= 1'b0;
        end else if (hold_ok) begin
            state       <= HOLD;
            holdCount   <= cnt_inc;
            holdExpired <= 1'b0;
        end else begin
            // Reaching here with hold=1 means the hold budget ran out: forced load.
            state       <= RUN;
            dataOut     <= dataIn;
            validOut    <= validIn;
            holdCount   <= '0;
            holdExpired <= hold;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three instances (MAX_HOLD = 1, 3, 0)
// share the stimulus; each scenario checks only the instance it targets.
module tb_pipe_stage_reg;

    localparam logic [63:0] NOP3 = 64'hDEAD_BEEF_0000_0013;
    localparam logic [63:0] A = 64'h0000_000A_1111_0000;
    localparam logic [63:0] B = 64'h0000_000B_2222_0000;
    localparam logic [63:0] C = 64'h0000_000C_3333_0000;
    localparam logic [63:0] D = 64'h0000_000D_4444_0000;
    localparam logic [63:0] E = 64'h0000_000E_5555_0000;
    localparam logic [63:0] F = 64'h0000_000F_6666_0000;

    logic        clk = 1'b0;
    logic        rst, hold, flush, validIn;
    logic [63:0] dataIn;

    logic        v1, h1, x1;
    logic [63:0] d1;
    logic [0:0]  c1;
    logic        v3, h3, x3;
    logic [63:0] d3;
    logic [1:0]  c3;
    logic        v0, h0, x0;
    logic [63:0] d0;
    logic [7:0]  c0;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    pipe_stage_reg #(.DATA_W(64), .MAX_HOLD(1)) u1 (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .validIn(validIn), .dataIn(dataIn),
        .validOut(v1), .dataOut(d1), .holding(h1), .holdCount(c1), .holdExpired(x1));

    pipe_stage_reg #(.DATA_W(64), .MAX_HOLD(3), .NOP_VALUE(NOP3)) u3 (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .validIn(validIn), .dataIn(dataIn),
        .validOut(v3), .dataOut(d3), .holding(h3), .holdCount(c3), .holdExpired(x3));

    pipe_stage_reg #(.DATA_W(64), .MAX_HOLD(0)) u0 (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .validIn(validIn), .dataIn(dataIn),
        .validOut(v0), .dataOut(d0), .holding(h0), .holdCount(c0), .holdExpired(x0));

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // driver tasks: inputs change 1 time unit after the edge, outputs are sampled there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic h, input logic f, input logic v, input logic [63:0] d);
        rst = r; hold = h; flush = f; validIn = v; dataIn = d;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        rst = 1'b0;
    endtask

    logic [63:0] t31_d [4];
    logic        t31_x [4];
    logic [1:0]  t32_c [5];
    logic [63:0] t32_d [5];
    logic        t32_x [5];
    logic [63:0] t35_d [3];
    logic        t35_v [3];

    initial begin
        t31_d = '{A, B, B, B};       t31_x = '{1'b0, 1'b1, 1'b0, 1'b1};
        t32_c = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        t32_d = '{NOP3, NOP3, NOP3, C, C};
        t32_x = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        t35_d = '{64'h1, 64'h2, 64'h3}; t35_v = '{1'b1, 1'b0, 1'b1};

        // reset overrides hold and flush
        drive(1'b1, 1'b1, 1'b1, 1'b1, 64'hFFFF);
        tick(); tick();
        check("rst_d1", d1, 64'h0);
        check("rst_v1", 64'(v1), 64'h0);
        check("rst_c1", 64'(c1), 64'h0);
        check("rst_h1", 64'(h1), 64'h0);
        check("rst_x1", 64'(x1), 64'h0);
        check("rst_d3", d3, NOP3);
        check("rst_c0", 64'(c0), 64'h0);
        check("rst_h0", 64'(h0), 64'h0);

        // MAX_HOLD=1: load A, then hold with B offered
        drive(1'b0, 1'b0, 1'b0, 1'b1, A);
        tick();
        check("mh1_load_d", d1, A);
        check("mh1_load_v", 64'(v1), 64'h1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, B);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("mh1_d[%0d]", i), d1, t31_d[i]);
            check($sformatf("mh1_x[%0d]", i), 64'(x1), 64'(t31_x[i]));
            check($sformatf("mh1_h[%0d]", i), 64'(h1), 64'(i % 2 == 0));
        end

        // MAX_HOLD=3: hold for 5 edges with C offered
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b1, C);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("mh3_c[%0d]", i), 64'(c3), 64'(t32_c[i]));
            check($sformatf("mh3_d[%0d]", i), d3, t32_d[i]);
            check($sformatf("mh3_x[%0d]", i), 64'(x3), 64'(t32_x[i]));
        end

        // flush in the middle of a hold
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1, D);
        tick();
        check("fl_load_d", d3, D);
        drive(1'b0, 1'b1, 1'b0, 1'b1, E);
        tick(); tick();
        check("fl_pre_c", 64'(c3), 64'h2);
        check("fl_pre_d", d3, D);
        flush = 1'b1;
        tick();
        check("fl_d", d3, NOP3);
        check("fl_v", 64'(v3), 64'h0);
        check("fl_c", 64'(c3), 64'h0);
        check("fl_h", 64'(h3), 64'h0);
        check("fl_x", 64'(x3), 64'h0);

        // reset mid-hold discards progress
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b1, E);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("rmid_c", 64'(c3), 64'h1);
        check("rmid_d", d3, NOP3);

        // MAX_HOLD=0: hold 300 edges, counter saturates, never expires
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1, E);
        tick();
        check("mh0_load_d", d0, E);
        drive(1'b0, 1'b1, 1'b0, 1'b0, F);
        for (int i = 1; i <= 300; i++) begin
            tick();
            check("mh0_d", d0, E);
            check("mh0_x", 64'(x0), 64'h0);
            check("mh0_c", 64'(c0), (i > 255) ? 64'd255 : 64'(i));
        end
        check("mh0_h", 64'(h0), 64'h1);
        hold = 1'b0;
        tick();
        check("mh0_rel_d", d0, F);
        check("mh0_rel_v", 64'(v0), 64'h0);
        check("mh0_rel_c", 64'(c0), 64'h0);
        check("mh0_rel_h", 64'(h0), 64'h0);

        // back-to-back loads with alternating valid
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, t35_v[i], t35_d[i]);
            exp_q.push_back({t35_d[i][62:0], t35_v[i]});
            tick();
            if (exp_q.size() != 0) begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check($sformatf("b2b_d[%0d]", i), d1, {1'b0, e[63:1]});
                check($sformatf("b2b_v[%0d]", i), 64'(v1), 64'(e[0]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
